// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the boot handshake bytes
// exchanged with the transmit side.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam logic [7:0] BOOT_READY = 8'h99;
    localparam logic [7:0] BOOT_DONE  = 8'hAA;

    // Counter width able to hold 0 .. (2*half - 1).
    function automatic int bit_cnt_width(input int half);
        return (half < 2) ? 2 : $clog2(2 * half);
    endfunction

endpackage

// File: rtl/uart_word_rx_if.sv
// Word-level receive bundle: serial line in, assembled words and error strobe out.
interface uart_word_rx_if;
    logic        rxd;
    logic [31:0] rword;
    logic        rword_ready;
    logic        ferr;

    modport master (
        input  rxd,
        output rword,
        output rword_ready,
        output ferr
    );

    modport slave (
        output rxd,
        input  rword,
        input  rword_ready,
        input  ferr
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser on rxd, mid-bit sampling FSM,
// single-cycle byte_valid / frame_err strobes at the stop-bit sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int BIT_PERIOD = 2 * CLK_PER_HALF_BIT;
    localparam int CW         = bit_cnt_width(CLK_PER_HALF_BIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);

    logic [1:0]    sync_reg;
    logic          rx_s;
    rx_state_t     state_reg;
    rx_state_t     state_next;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic          half_tick;
    logic          bit_tick;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
        end
    end

    assign rx_s      = sync_reg[1];
    assign half_tick = (cnt_reg == HALF_LAST);
    assign bit_tick  = (cnt_reg == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (!rx_s) state_next = START;
            START: if (half_tick) state_next = rx_s ? IDLE : DATA;
            DATA:  if (bit_tick && bit_reg == 3'd7) state_next = STOP;
            STOP:  if (bit_tick) state_next = rx_s ? IDLE : BREAK;
            BREAK: if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter restarts at each sample point so later samples stay centred in their bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg   <= '0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            case (state_reg)
                START: begin
                    cnt_reg <= half_tick ? '0 : cnt_reg + CW'(1);
                    bit_reg <= 3'd0;
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt_reg   <= '0;
                        bit_reg   <= bit_reg + 3'd1;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                STOP: begin
                    cnt_reg <= bit_tick ? '0 : cnt_reg + CW'(1);
                end
                default: begin
                    cnt_reg <= '0;
                    bit_reg <= 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (state_reg == STOP && bit_tick) begin
            byte_valid = rx_s;
            frame_err  = !rx_s;
        end
    end

    assign data_byte = shift_reg;

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: packs four bytes LSB-first into a 32-bit word and strobes
// rword_ready for one cycle; a framing error drops the partial word.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    uart_word_rx_if.master bus,
    input  logic           clk,
    input  logic           reset
);

    logic [7:0]  data_byte;
    logic        byte_valid;
    logic        frame_err;
    logic [1:0]  byte_idx_reg;
    logic [23:0] rword_buf;
    logic [31:0] rword_reg;
    logic        rword_ready_reg;
    logic        ferr_reg;

    uart_rx_byte #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .reset     (reset),
        .rxd       (bus.rxd),
        .data_byte (data_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // Lanes 0..2 are buffered; lane 3 goes straight into rword with the buffer.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] lane_reg;

        always_ff @(posedge clk) begin
            if (!reset) begin
                lane_reg <= 8'd0;
            end else if (byte_valid && byte_idx_reg == 2'(gi)) begin
                lane_reg <= data_byte;
            end
        end

        assign rword_buf[8*gi +: 8] = lane_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_idx_reg    <= 2'd0;
            rword_reg       <= 32'd0;
            rword_ready_reg <= 1'b0;
            ferr_reg        <= 1'b0;
        end else begin
            rword_ready_reg <= 1'b0;
            ferr_reg        <= frame_err;
            if (frame_err) begin
                byte_idx_reg <= 2'd0;
            end else if (byte_valid) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                if (byte_idx_reg == 2'd3) begin
                    rword_reg       <= {data_byte, rword_buf};
                    rword_ready_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.rword       = rword_reg;
    assign bus.rword_ready = rword_ready_reg;
    assign bus.ferr        = ferr_reg;

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx: drives 8N1 frames, queues expected words,
// and compares them as rword_ready pulses arrive.
module tb_uart_word_rx;
    import uart_pkg::*;

    localparam int HALF = 4;
    localparam int T    = 2 * HALF;
    localparam int FRAME_CYCLES = 10 * T;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_count = 0;
    int   ferr_count = 0;
    logic [31:0] exp_q[$];
    int          ready_times[$];

    uart_word_rx_if bus();

    uart_word_rx #(
        .CLK_PER_HALF_BIT(HALF)
    ) dut (
        .bus  (bus),
        .clk  (clk),
        .reset(reset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.rword_ready) begin
                check("no_overlap_ferr", 32'(bus.ferr), 32'd0);
                ready_count++;
                ready_times.push_back(cyc);
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("rword", bus.rword, e);
                    $display("word rword=%h exp=%h t=%0d", bus.rword, e, cyc);
                end
            end
            if (bus.ferr) begin
                ferr_count++;
                $display("ferr pulse t=%0d", cyc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rxd = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            repeat (T) @(negedge clk);
        end
        bus.rxd = stop_bit;
        repeat (T) @(negedge clk);
        bus.rxd = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back(w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic idle(input int n);
        bus.rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bus.rxd = 1'b1;
        reset   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rword", bus.rword, 32'd0);
        check("reset_ready", 32'(bus.rword_ready), 32'd0);
        check("reset_ferr", 32'(bus.ferr), 32'd0);
        reset = 1'b1;
        idle(10);

        // 1: basic word
        send_word(32'h12345678);
        idle(5);
        check("t1_ready_count", ready_count, 1);
        check("t1_ferr_count", ferr_count, 0);

        // 2: all-ones word then small value
        send_word(32'hFFFFFFFF);
        idle(5);
        send_word(32'h00000004);
        idle(5);
        check("t2_ready_count", ready_count, 3);

        // 3: short glitch is ignored
        bus.rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        check("t3_glitch_no_word", ready_count, 3);
        check("t3_glitch_no_ferr", ferr_count, 0);
        send_word(32'hA5C33C5A);
        idle(5);
        check("t3_ready_count", ready_count, 4);

        // 4: framing error on byte 2, then resync to a word boundary
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b0);
        idle(2 * T);
        check("t4_ferr_count", ferr_count, 1);
        check("t4_no_word", ready_count, 4);
        send_word({8'hDD, 8'hCC, 8'hBB, BOOT_DONE});
        idle(5);
        check("t4_ready_count", ready_count, 5);

        // 5: reset during byte 3 abandons the partial word
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        bus.rxd = 1'b0;
        repeat (4 * T) @(negedge clk);
        reset   = 1'b0;
        bus.rxd = 1'b1;
        @(negedge clk);
        check("t5_reset_rword", bus.rword, 32'd0);
        check("t5_reset_ready", 32'(bus.rword_ready), 32'd0);
        check("t5_reset_ferr", 32'(bus.ferr), 32'd0);
        reset = 1'b1;
        idle(FRAME_CYCLES);
        send_word(32'h44332211);
        idle(5);
        check("t5_ready_count", ready_count, 6);

        // 6: eight frames back-to-back
        base = ready_times.size();
        send_word({8'h01, 8'h02, 8'h03, BOOT_READY});
        send_word(32'hCAFEF00D);
        idle(5);
        check("t6_ready_count", ready_count, 8);
        if (ready_times.size() >= base + 2)
            check("t6_spacing", ready_times[base+1] - ready_times[base], 4 * FRAME_CYCLES);
        else
            check("t6_spacing_pulses", ready_times.size() - base, 2);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_ferr_count", ferr_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
